lock_entry_ctrl: RTL and testbench

Front-end for the pattern lock: conditions the raw 4-bit switch bank and the ENTER push-button, and presents each deliberate entry to the lock FSM as a registered 4-bit pattern with a one-cycle `pattern_valid` strobe. The lock uses this strobe as its state-advance enable. The block reads back the lock's per-entry verdict, counts consecutive wrong entries, and enforces a timed lockout after too many failures. It sits between board I/O and the lock FSM.

---
 rtl/lock_entry_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lock_entry_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_entry_ctrl.sv
// rtl/lock_entry_ctrl.sv - debounced pattern entry front-end for the pattern lock
// Optional failure counting and timed lockout built only when LOCK_ENTRY_LOCKOUT_EN is defined.
module lock_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MAX_FAILS       = 3,
  parameter int unsigned LOCKOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       enter_btn,
  input  logic       verdict_ok,
  input  logic       verdict_fail,
  input  logic       unlocked,
  output logic [3:0] pattern,
  output logic       pattern_valid,
  output logic       locked_out,
  output logic [3:0] fail_count,
  output logic       busy
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    PRESENT,
    REL_DB,
    LOCKOUT
  } state_e;

  state_e          state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]      pattern_q, pattern_d;
  logic [3:0]      sw_meta_q, sw_s_q;
  logic            btn_meta_q, btn_s_q;

`ifdef LOCK_ENTRY_LOCKOUT_EN
  localparam int LO_W = $clog2(LOCKOUT_CYCLES + 1);

  logic [LO_W-1:0] lo_cnt_q, lo_cnt_d;
  logic [3:0]      fail_cnt_q, fail_cnt_d;
  logic [3:0]      fail_inc;
  logic            entry_fail;
  logic            lo_done;
`else
  logic            unused_inputs;
  assign unused_inputs = ^{verdict_ok, verdict_fail, unlocked,
                           (MAX_FAILS == 0), (LOCKOUT_CYCLES == 0)};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      pattern_q  <= '0;
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
`ifdef LOCK_ENTRY_LOCKOUT_EN
      lo_cnt_q   <= '0;
      fail_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      pattern_q  <= pattern_d;
      sw_meta_q  <= sw;
      sw_s_q     <= sw_meta_q;
      btn_meta_q <= enter_btn;
      btn_s_q    <= btn_meta_q;
`ifdef LOCK_ENTRY_LOCKOUT_EN
      lo_cnt_q   <= lo_cnt_d;
      fail_cnt_q <= fail_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    pattern_d = pattern_q;
`ifdef LOCK_ENTRY_LOCKOUT_EN
    lo_cnt_d   = lo_cnt_q;
    lo_done    = 1'b0;
    entry_fail = verdict_fail | ~verdict_ok;
    fail_inc   = (fail_cnt_q == 4'd15) ? 4'd15 : fail_cnt_q + 4'd1;
`endif
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d  = PRESS_DB;
          db_cnt_d = DB_W'(1);
        end
      end
      PRESS_DB: begin
        if (!btn_s_q) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
          state_d   = PRESENT;
          pattern_d = sw_s_q;
          db_cnt_d  = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      PRESENT: begin
        state_d  = REL_DB;
        db_cnt_d = '0;
`ifdef LOCK_ENTRY_LOCKOUT_EN
        // An unlocked clear in the same cycle wins, so it also suppresses lockout.
        if (entry_fail && !unlocked && fail_inc == 4'(MAX_FAILS)) begin
          state_d  = LOCKOUT;
          lo_cnt_d = '0;
        end
`endif
      end
      REL_DB: begin
        if (btn_s_q) begin
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
`ifdef LOCK_ENTRY_LOCKOUT_EN
      LOCKOUT: begin
        if (lo_cnt_q == LO_W'(LOCKOUT_CYCLES - 1)) begin
          state_d  = REL_DB;
          lo_cnt_d = '0;
          db_cnt_d = '0;
          lo_done  = 1'b1;
        end else begin
          lo_cnt_d = lo_cnt_q + LO_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef LOCK_ENTRY_LOCKOUT_EN
    if (unlocked || lo_done) begin
      fail_cnt_d = '0;
    end else if (state_q == PRESENT && entry_fail) begin
      fail_cnt_d = fail_inc;
    end else begin
      fail_cnt_d = fail_cnt_q;
    end
`endif
  end

  always_comb begin
    pattern       = pattern_q;
    pattern_valid = (state_q == PRESENT);
    busy          = (state_q != IDLE);
`ifdef LOCK_ENTRY_LOCKOUT_EN
    locked_out    = (state_q == LOCKOUT);
    fail_count    = fail_cnt_q;
`else
    locked_out    = 1'b0;
    fail_count    = 4'd0;
`endif
  end

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// tb/tb_lock_entry_ctrl.sv - scoreboard bench for lock_entry_ctrl against a run-length reference model
module tb_lock_entry_ctrl;

  localparam int D  = 4;
  localparam int MF = 3;
  localparam int LC = 64;

  localparam int ARMED      = 0;
  localparam int PRESENTING = 1;
  localparam int LOCKED     = 2;
  localparam int RELEASING  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       enter_btn = 1'b0;
  logic       verdict_ok = 1'b0;
  logic       verdict_fail = 1'b0;
  logic       unlocked = 1'b0;
  logic [3:0] pattern;
  logic       pattern_valid;
  logic       locked_out;
  logic [3:0] fail_count;
  logic       busy;

  always #5 clk = ~clk;

  lock_entry_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .MAX_FAILS(MF),
    .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .enter_btn(enter_btn),
    .verdict_ok(verdict_ok),
    .verdict_fail(verdict_fail),
    .unlocked(unlocked),
    .pattern(pattern),
    .pattern_valid(pattern_valid),
    .locked_out(locked_out),
    .fail_count(fail_count),
    .busy(busy)
  );

  typedef struct {
    int         cyc;
    logic [3:0] pat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   rnd_verdict = 1'b0;

  int         m_mode, hi_run, lo_run, lo_left, m_fc;
  logic [3:0] m_pat, s1_sw, s2_sw, ss;
  logic       s1_b, s2_b, bs, m_fail;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference: the ENTER line seen two edges late; an entry is D+1 consecutive
  // high samples while armed, re-armed by D consecutive low samples.
  initial begin
    m_mode = ARMED; hi_run = 0; lo_run = 0; lo_left = 0; m_fc = 0;
    m_pat = 0; s1_sw = 0; s2_sw = 0; s1_b = 0; s2_b = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_mode = ARMED; hi_run = 0; lo_run = 0; lo_left = 0; m_fc = 0;
        m_pat = 0; s1_sw = 0; s2_sw = 0; s1_b = 0; s2_b = 0;
        sb.delete();
      end else begin
        bs = s2_b; ss = s2_sw;
        s2_b = s1_b; s1_b = enter_btn;
        s2_sw = s1_sw; s1_sw = sw;
        m_fail = verdict_fail || !verdict_ok;
        case (m_mode)
          ARMED: begin
            if (bs) begin
              hi_run++;
              if (hi_run == D + 1) begin
                m_pat = ss;
                sb.push_back('{cyc, ss});
                m_mode = PRESENTING;
                hi_run = 0;
              end
            end else begin
              hi_run = 0;
            end
          end
          PRESENTING: begin
            m_mode = RELEASING;
            lo_run = 0;
`ifdef LOCK_ENTRY_LOCKOUT_EN
            if (m_fail && !unlocked) begin
              m_fc = (m_fc < 15) ? m_fc + 1 : 15;
              if (m_fc == MF) begin
                m_mode = LOCKED;
                lo_left = LC;
              end
            end
`endif
          end
          LOCKED: begin
            lo_left--;
            if (lo_left == 0) begin
              m_fc = 0;
              m_mode = RELEASING;
              lo_run = 0;
            end
          end
          default: begin
            if (bs) begin
              lo_run = 0;
            end else begin
              lo_run++;
              if (lo_run == D) begin
                m_mode = ARMED;
                hi_run = 0;
              end
            end
          end
        endcase
        if (unlocked) m_fc = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("pattern_valid", int'(pattern_valid), int'(m_mode == PRESENTING));
      chk("pattern", int'(pattern), int'(m_pat));
      chk("locked_out", int'(locked_out), int'(m_mode == LOCKED));
      chk("fail_count", int'(fail_count), m_fc);
      chk("busy", int'(busy), int'(!(m_mode == ARMED && hi_run == 0)));
      if (pattern_valid) begin
        chk("strobe_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("strobe_pattern", int'(pattern), int'(e.pat));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      if (rnd_verdict) begin
        verdict_fail = 1'($urandom % 2);
        verdict_ok   = 1'($urandom % 2);
        unlocked     = ($urandom % 40) == 0;
      end
    end
  endtask

  task automatic press(input logic [3:0] v, input int hold, input int rel, input bit bouncy);
    sw = v;
    if (bouncy) begin
      enter_btn = 1'b1; step(2);
      enter_btn = 1'b0; step(1);
    end
    enter_btn = 1'b1; step(hold);
    enter_btn = 1'b0; step(rel);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pattern"}, int'(pattern), 0);
    chk({tag, "_pattern_valid"}, int'(pattern_valid), 0);
    chk({tag, "_locked_out"}, int'(locked_out), 0);
    chk({tag, "_fail_count"}, int'(fail_count), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int seen;
    step(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    verdict_ok = 1'b1; verdict_fail = 1'b0; unlocked = 1'b0;
    step(4);

    // Clean press: strobe D+2 edges after the first edge that samples ENTER high.
    sw = 4'b0011;
    enter_btn = 1'b1;
    k = cyc + 1;
    seen = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pattern_valid) begin
        seen = cyc;
        break;
      end
    end
    #1;
    chk("press_latency", seen, k + 2 + D);
    chk("press_pattern", int'(pattern), 3);
    step(6);
    enter_btn = 1'b0;
    step(D + 4);

    press(4'h5, 12, 10, 1'b1);

    // Three wrong entries, the last one held straight through the lockout.
    verdict_ok = 1'b0; verdict_fail = 1'b1;
    press(4'h9, 10, 10, 1'b0);
    press(4'hA, 10, 10, 1'b0);
    press(4'hB, LC + 30, 12, 1'b0);
    chk("fail_after_lockout", int'(fail_count), 0);

    // Unlocked clears the count; the next failure starts again from one.
    press(4'h1, 10, 10, 1'b0);
    press(4'h2, 10, 10, 1'b0);
    unlocked = 1'b1; step(1); unlocked = 1'b0;
    press(4'h3, 10, 10, 1'b0);
    chk("locked_out_after_clear", int'(locked_out), 0);
    unlocked = 1'b1; step(1); unlocked = 1'b0;

    // Reset while debouncing a held press, then release reset with it still held.
    verdict_ok = 1'b1; verdict_fail = 1'b0;
    sw = 4'h6;
    enter_btn = 1'b1;
    step(4);
    chk("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    step(2);
    rst_n = 1'b1;
    step(D + 10);
    enter_btn = 1'b0;
    step(D + 5);

    rnd_verdict = 1'b1;
    repeat (80) begin
      press(4'($urandom), int'($urandom_range(1, 30)), int'($urandom_range(1, 20)),
            ($urandom % 3) == 0);
    end
    rnd_verdict = 1'b0;
    unlocked = 1'b0;
    enter_btn = 1'b0;
    step(LC + 3 * D + 20);
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
